// File: rtl/ram_burst_gen_if.sv
// Command, SRAM read port and status bundle for ram_burst_gen.
// The master side is the requester plus the SRAM; the slave side is the generator.
interface ram_burst_gen_if #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned COUNT_WIDTH = 8
);
  logic                   go;
  logic                   abort;
  logic [ADDR_WIDTH-1:0]  addr;
  logic [ADDR_WIDTH-1:0]  stride;
  logic [COUNT_WIDTH-1:0] count;
  logic [1:0]             op;
  logic                   sram_select;
  logic [ADDR_WIDTH-1:0]  sram_address;
  logic [DATA_WIDTH-1:0]  sram_read_data;
  logic                   busy;
  logic                   done;
  logic [DATA_WIDTH-1:0]  data;

  modport master (
    output go, abort, addr, stride, count, op, sram_read_data,
    input  sram_select, sram_address, busy, done, data
  );

  modport slave (
    input  go, abort, addr, stride, count, op, sram_read_data,
    output sram_select, sram_address, busy, done, data
  );
endinterface

// File: rtl/ram_burst_gen.sv
// Strided SRAM burst reader that folds the words into a sum/xor/max/min result.
// Reads are pipelined: each word arrives one cycle after its strobe.
module ram_burst_gen #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned COUNT_WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  ram_burst_gen_if.slave   bus_io
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e                 state_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [ADDR_WIDTH-1:0]  stride_q;
  logic [COUNT_WIDTH-1:0] remain_q;
  logic [1:0]             op_q;
  logic [DATA_WIDTH-1:0]  acc_q;
  logic [DATA_WIDTH-1:0]  data_q;
  logic                   rvalid_q;
  logic                   sel_q;
  logic                   busy_q;
  logic                   done_q;

  logic [DATA_WIDTH-1:0]  acc_d;
  logic [DATA_WIDTH-1:0]  acc_init;

  function automatic logic [DATA_WIDTH-1:0] fold(input logic [1:0]            op,
                                                 input logic [DATA_WIDTH-1:0] acc,
                                                 input logic [DATA_WIDTH-1:0] word);
    case (op)
      2'd0:    return acc + word;
      2'd1:    return acc ^ word;
      2'd2:    return (word > acc) ? word : acc;
      default: return (word < acc) ? word : acc;
    endcase
  endfunction

  always_comb begin
    acc_init = (bus_io.op == 2'd3) ? {DATA_WIDTH{1'b1}} : {DATA_WIDTH{1'b0}};
    acc_d    = rvalid_q ? fold(op_q, acc_q, bus_io.sram_read_data) : acc_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      stride_q <= '0;
      remain_q <= '0;
      op_q     <= '0;
      acc_q    <= '0;
      data_q   <= '0;
      rvalid_q <= 1'b0;
      sel_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      rvalid_q <= sel_q;
      acc_q    <= acc_d;
      unique case (state_q)
        StIdle: begin
          if (bus_io.go && !bus_io.abort) begin
            stride_q <= bus_io.stride;
            remain_q <= bus_io.count;
            op_q     <= bus_io.op;
            acc_q    <= acc_init;
            busy_q   <= 1'b1;
            if (bus_io.count == '0) begin
              data_q  <= acc_init;
              done_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              addr_q  <= bus_io.addr;
              sel_q   <= 1'b1;
              state_q <= StRun;
            end
          end
        end
        StRun: begin
          if (bus_io.abort) begin
            sel_q    <= 1'b0;
            busy_q   <= 1'b0;
            rvalid_q <= 1'b0;
            state_q  <= StIdle;
          end else begin
            remain_q <= remain_q - 1'b1;
            // Final read: keep the address on the last word issued.
            if (remain_q == COUNT_WIDTH'(1)) begin
              sel_q   <= 1'b0;
              state_q <= StDrain;
            end else begin
              addr_q <= addr_q + stride_q;
            end
          end
        end
        StDrain: begin
          if (bus_io.abort) begin
            busy_q   <= 1'b0;
            rvalid_q <= 1'b0;
            state_q  <= StIdle;
          end else begin
            data_q  <= acc_d;
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus_io.sram_select  = sel_q;
  assign bus_io.sram_address = addr_q;
  assign bus_io.busy         = busy_q;
  assign bus_io.done         = done_q;
  assign bus_io.data         = data_q;

endmodule

// File: doc/ram_burst_gen.md
RAM_BURST_GEN -- requirements
Module: ram_burst_gen

Interface
REQ-001 Parameter DATA_WIDTH, default 16, SHALL set SRAM data, accumulator and result width.
REQ-002 Parameter ADDR_WIDTH, default 16, SHALL set address and stride width.
REQ-003 Parameter COUNT_WIDTH, default 8, SHALL set burst-length width.
REQ-004 clk  input  1  SHALL be the single clock; all state on rising edge.
REQ-005 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-006 go  input  1  SHALL request a burst; sampled only in IDLE.
REQ-007 abort  input  1  SHALL cancel an active burst.
REQ-008 addr  input  ADDR_WIDTH  SHALL give the start address, sampled with go.
REQ-009 stride  input  ADDR_WIDTH  SHALL give the address increment, sampled with go.
REQ-010 count  input  COUNT_WIDTH  SHALL give the number of words to read, sampled with go.
REQ-011 op  input  2  SHALL select the reduction: 0 sum, 1 xor, 2 unsigned max, 3 unsigned min; sampled with go.
REQ-012 sram_select  output  1  SHALL be the SRAM read strobe.
REQ-013 sram_address  output  ADDR_WIDTH  SHALL be the SRAM read address.
REQ-014 sram_read_data  input  DATA_WIDTH  SHALL be valid one cycle after sram_select.
REQ-015 busy  output  1  SHALL be high in RUN, DRAIN and DONE.
REQ-016 done  output  1  SHALL be a one-cycle completion pulse.
REQ-017 data  output  DATA_WIDTH  SHALL be the last completed result.

Function
REQ-018 FSM states SHALL be IDLE, RUN, DRAIN and DONE.
REQ-019 IDLE with go=1 and abort=0 SHALL, at the edge, latch addr, stride, count and op, and initialise the accumulator (0 for ops 0-2, all-ones for op 3).
- count=0: next state DONE.
- count>0: next state RUN.
REQ-020 In RUN, sram_select SHALL be 1 and sram_address SHALL equal the current address.
- Each edge: address += stride, modulo 2^ADDR_WIDTH; remaining -= 1.
- The edge issuing the last read (remaining=1) SHALL move to DRAIN.
REQ-021 A read-valid flag SHALL be registered from sram_select; when set, the accumulator SHALL fold in sram_read_data per op at the next edge.
- Sum truncates to DATA_WIDTH; no carry or overflow output.
REQ-022 DRAIN SHALL last one cycle, fold in the final word and move to DONE.
REQ-023 Entering DONE SHALL copy the accumulator to data.
- done=1 for exactly the DONE cycle; DONE then returns to IDLE.
- go in DONE SHALL be ignored.
REQ-024 Latency: for count=N>0, done SHALL be high during the cycle following edge N+1 after the go-sampling edge.
- For count=0, done SHALL be high during the cycle following edge 1, with data = the op initial value.
REQ-025 sram_select SHALL be 0 outside RUN; sram_address SHALL hold its last value.
REQ-026 abort=1 in RUN or DRAIN SHALL force IDLE at the next edge: no done, data unchanged, and any pending read-valid discarded.
REQ-027 abort=1 in IDLE SHALL take priority over go (burst not started); abort in DONE SHALL have no effect.
REQ-028 data SHALL hold between completions and SHALL NOT change on an aborted burst.

Reset
REQ-029 reset=1 SHALL immediately force the following, asynchronously and including mid-burst:
- state IDLE;
- busy, done and sram_select to 0;
- sram_address, data, accumulator, remaining count and read-valid to 0.
REQ-030 After reset deasserts, the first go SHALL be accepted on the first edge.

Verification
REQ-031 SRAM[0x10..0x13]=1,2,3,4; go with addr=0x10, stride=1, count=4, op=0 -> selects at 0x10-0x13 on consecutive cycles; done one cycle with data=10, exactly 5 edges after go.
REQ-032 addr=0xFFFE, stride=1, count=3 -> reads 0xFFFE, 0xFFFF, 0x0000 (wrap); op=2 over 5,9,3 -> data=9; op=3 -> data=3.
REQ-033 count=0, op=3 -> no sram_select; done on the cycle following edge 1 with data=0xFFFF (16-bit).
REQ-034 Sum of 0xFFFF and 0x0002 (op 0) -> data=0x0001; xor of 0x00FF and 0x0F0F (op 1) -> data=0x0FF0; stride=4 -> addresses step by 4.
REQ-035 abort in the second RUN cycle of a count=8 burst -> IDLE at the next edge, no done, data retains previous 10; go with abort in IDLE -> no burst.
REQ-036 reset asserted mid-RUN -> immediately busy=0, sram_select=0, data=0; a new burst after release completes correctly.
